// File: rtl/counter_sweep_pkg.sv
// Shared types and default sizes for the counter sweep controller.
// State encoding and the default operand widths live here.
package counter_sweep_pkg;

  localparam int DEF_WIDTH  = 12;
  localparam int DEF_STEP_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/counter_sweep_ctrl_if.sv
// Command/status bundle between a command source and the sweep controller.
// master = command source, slave = counter_sweep_ctrl.
interface counter_sweep_ctrl_if #(
  parameter int WIDTH  = 12,
  parameter int STEP_W = 4
);

  logic              start_in;
  logic              abort_in;
  logic [WIDTH-1:0]  start_val_in;
  logic [WIDTH-1:0]  end_val_in;
  logic [STEP_W-1:0] step_in;
  logic [WIDTH-1:0]  count_out;
  logic              dir_out;
  logic              busy_out;
  logic              done_out;
  logic              err_out;

  modport master (
    output start_in,
    output abort_in,
    output start_val_in,
    output end_val_in,
    output step_in,
    input  count_out,
    input  dir_out,
    input  busy_out,
    input  done_out,
    input  err_out
  );

  modport slave (
    input  start_in,
    input  abort_in,
    input  start_val_in,
    input  end_val_in,
    input  step_in,
    output count_out,
    output dir_out,
    output busy_out,
    output done_out,
    output err_out
  );

endinterface

// File: rtl/sweep_step_unit.sv
// Combinational step/clamp for one sweep edge.
// Distance is taken in WIDTH+1 bits so the clamp never wraps.
module sweep_step_unit #(
  parameter int WIDTH  = 12,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  i_count,
  input  logic [WIDTH-1:0]  i_end,
  input  logic [STEP_W-1:0] i_step,
  input  logic              i_dir,
  output logic [WIDTH-1:0]  o_next,
  output logic              o_reached
);

  logic [WIDTH-1:0] w_step;
  logic [WIDTH:0]   w_dist;

  assign w_step = {{(WIDTH-STEP_W){1'b0}}, i_step};

  assign w_dist = i_dir ?
    ({1'b0, i_end} - {1'b0, i_count}) :
    ({1'b0, i_count} - {1'b0, i_end});

  assign o_reached = (w_dist <= {1'b0, w_step});

  always_comb begin
    o_next = i_end;
    if (!o_reached) begin
      if (i_dir) o_next = i_count + w_step;
      else       o_next = i_count - w_step;
    end
  end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Up/down sweep sequencer: load, step with end clamp, done pulse.
// Define SWEEP_PINGPONG_EN to bounce between endpoints until abort.
module counter_sweep_ctrl
  import counter_sweep_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic clk_in,
  input  logic rst_in,
  counter_sweep_ctrl_if.slave bus
);

  state_e            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_count, w_count_nxt;
  logic [WIDTH-1:0]  r_start, w_start_nxt;
  logic [WIDTH-1:0]  r_end, w_end_nxt;
  logic [STEP_W-1:0] r_step, w_step_nxt;
  logic              r_dir, w_dir_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;

  logic [WIDTH-1:0]  w_next;
  logic              w_reached;

  sweep_step_unit #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_step (
    .i_count   (r_count),
    .i_end     (r_end),
    .i_step    (r_step),
    .i_dir     (r_dir),
    .o_next    (w_next),
    .o_reached (w_reached)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= IDLE;
      r_count <= '0;
      r_start <= '0;
      r_end   <= '0;
      r_step  <= '0;
      r_dir   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_start <= w_start_nxt;
      r_end   <= w_end_nxt;
      r_step  <= w_step_nxt;
      r_dir   <= w_dir_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_start_nxt = r_start;
    w_end_nxt   = r_end;
    w_step_nxt  = r_step;
    w_dir_nxt   = r_dir;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    unique case (r_state)
      IDLE: begin
        // abort in the same cycle silently cancels the start
        if (bus.start_in && !bus.abort_in) begin
          if (bus.step_in == '0) begin
            w_err_nxt = 1'b1;
          end else begin
            w_start_nxt = bus.start_val_in;
            w_end_nxt   = bus.end_val_in;
            w_step_nxt  = bus.step_in;
            w_dir_nxt   = (bus.end_val_in >= bus.start_val_in);
            w_state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        if (bus.abort_in) begin
          w_state_nxt = IDLE;
        end else begin
          w_count_nxt = r_start;
          if (r_start == r_end) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (bus.abort_in) begin
          w_state_nxt = IDLE;
        end else begin
          w_count_nxt = w_next;
          if (w_reached) begin
            w_done_nxt = 1'b1;
`ifdef SWEEP_PINGPONG_EN
            w_start_nxt = r_end;
            w_end_nxt   = r_start;
            w_dir_nxt   = !r_dir;
`else
            w_state_nxt = DONE;
`endif
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == LOAD) || (w_state_nxt == RUN);
  end

  assign bus.count_out = r_count;
  assign bus.dir_out   = r_dir;
  assign bus.busy_out  = r_busy;
  assign bus.done_out  = r_done;
  assign bus.err_out   = r_err;

endmodule
